trigger_seq: RTL

TRIGGER_SEQ -- requirements
Module: trigger_seq

---
 rtl/trigger_seq.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/trigger_seq.sv
// trigger_seq: two-stage stream trigger sequencer; a bus-programmed table maps {match, cnt_done, state}
// to next state, event and counter controls. Define TRIGGER_EDGE_EN to build edge-mode matchers.
//   state | meaning
//   0     | idle / cleared; held here while disarmed
//   1..   | sequence steps, meaning defined by the table contents
module trigger_seq #(
    parameter int BAW = 8,
    parameter int BDW = 32,
    parameter int SDW = 32,
    parameter int SEW = 2,
    parameter int TMN = 4,
    parameter int TCN = 2,
    parameter int TCW = 16,
    parameter int TSW = 4
) (
    input  logic           clk,
    input  logic           rst,
    output logic           bus_wready,
    input  logic           bus_wvalid,
    input  logic [BAW-1:0] bus_waddr,
    input  logic [BDW-1:0] bus_wdata,
    input  logic [3:0]     bus_wselct,
    output logic           sti_tready,
    input  logic           sti_tvalid,
    input  logic [SDW-1:0] sti_tdata,
    input  logic           sto_tready,
    output logic           sto_tvalid,
    output logic [SEW-1:0] sto_tevent,
    output logic [SDW-1:0] sto_tdata
);
    localparam int TEW = TMN + TCN;
    localparam int TAW = TSW + TEW;
    localparam int TDW = TSW + SEW + 2 * TCN;

    logic           bus_we;
    logic           soft_clr;
    logic           adv;
    logic           arm;
    logic [SDW-1:0] mask  [TMN];
    logic [SDW-1:0] value [TMN];
    logic [TCW-1:0] cmp   [TCN];
    logic [TDW-1:0] tbl   [2**TAW];
`ifdef TRIGGER_EDGE_EN
    logic [TMN-1:0] mode;
    logic [TMN-1:0] prev_match;
`endif

    logic [TMN-1:0] raw_match;
    logic [TMN-1:0] match_in;
    logic           s1_valid;
    logic [SDW-1:0] s1_data;
    logic [TMN-1:0] s1_match;

    logic [TSW-1:0] state;
    logic [TSW-1:0] state_nxt;
    logic [TCW-1:0] cnt     [TCN];
    logic [TCW-1:0] cnt_nxt [TCN];
    logic [TCN-1:0] cnt_done;
    logic [SEW-1:0] evt_nxt;

    logic [TAW-1:0] tbl_raddr;
    logic [TDW-1:0] tbl_rd;
    logic [TSW-1:0] tbl_next;
    logic [SEW-1:0] tbl_evt;
    logic [TCN-1:0] tbl_inc;
    logic [TCN-1:0] tbl_clr;

    assign bus_wready = ~rst;
    assign bus_we     = bus_wvalid & bus_wready;
    assign soft_clr   = bus_we & bus_wselct[3] & (bus_waddr == '0) & bus_wdata[1];
    assign adv        = ~sto_tvalid | sto_tready;
    assign sti_tready = adv & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm <= 1'b0;
            for (int i = 0; i < TMN; i++) begin
                mask[i]  <= '0;
                value[i] <= '0;
            end
            for (int j = 0; j < TCN; j++) cmp[j] <= '0;
`ifdef TRIGGER_EDGE_EN
            mode <= '0;
`endif
        end else if (bus_we) begin
            for (int i = 0; i < TMN; i++) begin
                if (bus_wselct[0] && bus_waddr[BAW-1:3] == (BAW-3)'(i)) begin
                    case (bus_waddr[2:0])
                        3'd0:    mask[i]  <= SDW'(bus_wdata);
                        3'd1:    value[i] <= SDW'(bus_wdata);
`ifdef TRIGGER_EDGE_EN
                        3'd2:    mode[i]  <= bus_wdata[0];
`endif
                        default: ;
                    endcase
                end
            end
            for (int j = 0; j < TCN; j++) begin
                if (bus_wselct[2] && bus_waddr == BAW'(j)) cmp[j] <= TCW'(bus_wdata);
            end
            if (bus_wselct[3] && bus_waddr == '0) arm <= bus_wdata[0];
        end
    end

    // Table has no reset; reads are combinational so a same-cycle write is seen only by later samples.
    always_ff @(posedge clk) begin
        if (bus_we && bus_wselct[1]) tbl[TAW'(bus_waddr)] <= TDW'(bus_wdata);
    end

    always_comb begin
        for (int i = 0; i < TMN; i++) begin
            raw_match[i] = ((sti_tdata ^ value[i]) & mask[i]) == '0;
`ifdef TRIGGER_EDGE_EN
            match_in[i] = mode[i] ? (raw_match[i] & ~prev_match[i]) : raw_match[i];
`else
            match_in[i] = raw_match[i];
`endif
        end
    end

    always_comb begin
        for (int j = 0; j < TCN; j++) cnt_done[j] = (cnt[j] == cmp[j]);
    end

    assign tbl_raddr = {s1_match, cnt_done, state};
    assign tbl_rd    = tbl[tbl_raddr];
    assign tbl_next  = tbl_rd[TSW-1:0];
    assign tbl_evt   = tbl_rd[TSW +: SEW];
    assign tbl_inc   = tbl_rd[TSW+SEW +: TCN];
    assign tbl_clr   = tbl_rd[TSW+SEW+TCN +: TCN];

    // Next state and counters; clear beats increment, increment saturates.
    always_comb begin
        state_nxt = state;
        for (int j = 0; j < TCN; j++) cnt_nxt[j] = cnt[j];
        if (!arm) begin
            state_nxt = '0;
            for (int j = 0; j < TCN; j++) cnt_nxt[j] = '0;
        end else if (adv && s1_valid) begin
            state_nxt = tbl_next;
            for (int j = 0; j < TCN; j++) begin
                if (tbl_clr[j])                      cnt_nxt[j] = '0;
                else if (tbl_inc[j] && cnt[j] != '1) cnt_nxt[j] = cnt[j] + TCW'(1);
            end
        end
    end

    always_comb begin
        evt_nxt = '0;
        if (arm && s1_valid) evt_nxt = tbl_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= '0;
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_match   <= '0;
            sto_tvalid <= 1'b0;
            sto_tevent <= '0;
            sto_tdata  <= '0;
            for (int j = 0; j < TCN; j++) cnt[j] <= '0;
`ifdef TRIGGER_EDGE_EN
            prev_match <= '0;
`endif
        end else if (soft_clr) begin
            state      <= '0;
            s1_valid   <= 1'b0;
            sto_tvalid <= 1'b0;
            for (int j = 0; j < TCN; j++) cnt[j] <= '0;
`ifdef TRIGGER_EDGE_EN
            prev_match <= '0;
`endif
        end else begin
            state <= state_nxt;
            for (int j = 0; j < TCN; j++) cnt[j] <= cnt_nxt[j];
            if (adv) begin
                s1_valid   <= sti_tvalid;
                sto_tvalid <= s1_valid;
                if (sti_tvalid) begin
                    s1_data  <= sti_tdata;
                    s1_match <= match_in;
`ifdef TRIGGER_EDGE_EN
                    prev_match <= raw_match;
`endif
                end
                if (s1_valid) begin
                    sto_tdata  <= s1_data;
                    sto_tevent <= evt_nxt;
                end
            end
        end
    end
endmodule
